key_expand: RTL and testbench
=============================

KEY_EXPAND -- requirements
Module: key_expand

Interface
REQ-001 The block SHALL have no parameters; AES-128 only (Nk=4, Nr=10, 11 round keys).
REQ-002 The block SHALL have exactly one clock and an asynchronous, active-low reset.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset; assertion is asynchronous, deassertion is synchronised externally.
REQ-005 start  input  1  single-cycle request to begin expansion of key_in; sampled only in IDLE.
REQ-006 key_in  input  128  cipher key; word w0 = key_in[127:96], w3 = key_in[31:0].
REQ-007 rk_ready  input  1  downstream ready for the current round key.
REQ-008 round_key  output  128  current round key, same word ordering as key_in.
REQ-009 round_idx  output  4  index of round_key, 0..10.
REQ-010 rk_valid  output  1  round_key/round_idx are valid.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 done  output  1  one-cycle pulse after round key 10 is accepted.

Function
REQ-013 The FSM SHALL have two states, IDLE and EMIT; busy = (state == EMIT).
REQ-014 In IDLE with start=1, the block SHALL latch key_in into round_key, set round_idx=0 and rk_valid=1, and enter EMIT on the same edge; latency from start to rk_valid is 1 cycle.
REQ-015 In IDLE, start=0 SHALL leave all outputs unchanged, with rk_valid=0.
REQ-016 A handshake SHALL occur on a rising edge where rk_valid=1 and rk_ready=1.
REQ-017 While rk_valid=1 and rk_ready=0, round_key and round_idx SHALL hold stable.
REQ-018 On a handshake with round_idx<10, the block SHALL load the next round key and increment round_idx on that same edge, keeping rk_valid=1; sustained throughput is one key per cycle.
REQ-019 Next-key computation SHALL be as follows:
- temp = SubWord(RotWord(w3)) XOR {rcon[round_idx+1], 24'h0}
- w4 = w0^temp; w5 = w1^w4; w6 = w2^w5; w7 = w3^w6
- new round_key = {w4,w5,w6,w7}
REQ-020 RotWord SHALL map {a,b,c,d} to {b,c,d,a}; SubWord SHALL apply the AES S-box to each byte.
REQ-021 rcon[1..10] SHALL be 01,02,04,08,10,20,40,80,1b,36.
REQ-022 On a handshake with round_idx==10, the block SHALL clear rk_valid, return to IDLE, and assert done for exactly the following cycle.
REQ-023 round_key and round_idx SHALL retain their last values in IDLE.
REQ-024 start asserted while busy=1, including in the final-handshake cycle, SHALL be ignored.
REQ-025 rk_ready SHALL be ignored when rk_valid=0.
REQ-026 All XOR logic SHALL be purely bitwise with no carries; round_idx SHALL never exceed 10.

Reset
REQ-027 On rst_n=0, the block SHALL immediately force: state=IDLE, round_key=0, round_idx=0, rk_valid=0, busy=0, done=0.
REQ-028 Reset asserted mid-expansion SHALL abort the expansion; no stale key is emitted afterwards, and the next start begins from round 0.

Structure
REQ-029 A shared package aes_pkg SHALL hold: the rcon table, the constant NR=10, the 2-state FSM enum, and the RotWord helper.
REQ-030 SubWord SHALL be implemented by instantiating the existing combinational 32-bit row S-box module s_box once, fed with RotWord(w3).
REQ-031 The next-key datapath SHALL be combinational from the round_key register; there SHALL be no extra pipeline stage.

Verification
REQ-032 FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready=1 -> idx0 = key; idx1 = a0fafe1788542cb123a339392a6c7605; idx10 = d014f9a8c9ee2589e13f0cc8b6630ca6; done pulses 1 cycle after idx10 is accepted; 11 consecutive valid cycles.
REQ-033 All-zero key -> idx1 = 62636363626363636263636362636363; idx10 = b4ef5bcb3e92e21123e951cf6f8f188e.
REQ-034 Random rk_ready back-pressure (about 50%) on the FIPS key -> key sequence identical to REQ-032; round_key stable during every stall cycle; no keys dropped or duplicated.
REQ-035 start pulsed at idx 4 and again on the final-handshake cycle -> both ignored; sequence unaffected; exactly one done.
REQ-036 rst_n pulled low at idx 6 -> outputs reach reset values without waiting for clk; a subsequent start with the zero key yields idx0 = 0 and then the REQ-033 sequence.

Source files
------------

// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES-128 key schedule constants, FSM encoding and RotWord helper
package aes_pkg;

  // Number of rounds for AES-128; round keys are indexed 0..NR.
  localparam logic [3:0] NR = 4'd10;

  // Two-state key expansion controller.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } ke_state_e;

  // Round constants indexed by round number; entry 0 and 11..15 are padding so a
  // 4-bit index can never read outside the table.
  localparam logic [7:0] RCON [16] = '{
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
    8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
  };

  // Cyclic left byte rotation: {a,b,c,d} -> {b,c,d,a}.
  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/s_box.sv
// rtl/s_box.sv - combinational AES S-box applied to each byte of a 32-bit word
module s_box (
  input  logic [31:0] word,
  output logic [31:0] sub_word
);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Four independent byte lookups; no interaction between lanes.
  always_comb begin
    sub_word = '0;
    for (int i = 0; i < 4; i++) begin
      sub_word[8*i +: 8] = SBOX[word[8*i +: 8]];
    end
  end

endmodule

// File: rtl/key_expand.sv
// rtl/key_expand.sv - AES-128 key expansion emitting one round key per handshake
module key_expand
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] key_in,
  input  logic         rk_ready,
  output logic [127:0] round_key,
  output logic [3:0]   round_idx,
  output logic         rk_valid,
  output logic         busy,
  output logic         done
);

  ke_state_e    state, state_nxt;
  logic [127:0] key_nxt;
  logic [3:0]   idx_nxt;
  logic         done_nxt;

  logic [31:0]  w0, w1, w2, w3, w4, w5, w6, w7;
  logic [31:0]  rot, sub, temp;
  logic [127:0] next_rk;
  logic         hs;

  // Next round key is derived combinationally from the current one.
  assign w0   = round_key[127:96];
  assign w1   = round_key[95:64];
  assign w2   = round_key[63:32];
  assign w3   = round_key[31:0];
  assign rot  = rot_word(w3);

  s_box u_s_box (
    .word     (rot),
    .sub_word (sub)
  );

  assign temp    = sub ^ {RCON[round_idx + 4'd1], 24'h0};
  assign w4      = w0 ^ temp;
  assign w5      = w1 ^ w4;
  assign w6      = w2 ^ w5;
  assign w7      = w3 ^ w6;
  assign next_rk = {w4, w5, w6, w7};

  // The only state with a key on offer is EMIT, so valid and busy coincide.
  assign rk_valid = (state == ST_EMIT);
  assign busy     = (state == ST_EMIT);
  assign hs       = rk_valid & rk_ready;

  // Next-state and next-output decode; start is only looked at in IDLE.
  always_comb begin
    state_nxt = state;
    key_nxt   = round_key;
    idx_nxt   = round_idx;
    done_nxt  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          key_nxt   = key_in;
          idx_nxt   = 4'd0;
          state_nxt = ST_EMIT;
        end
      end
      ST_EMIT: begin
        if (hs) begin
          if (round_idx == NR) begin
            state_nxt = ST_IDLE;
            done_nxt  = 1'b1;
          end else begin
            key_nxt = next_rk;
            idx_nxt = round_idx + 4'd1;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State and output registers; reset aborts any expansion in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      round_key <= '0;
      round_idx <= 4'd0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      round_key <= key_nxt;
      round_idx <= idx_nxt;
      done      <= done_nxt;
    end
  end

endmodule

// File: tb/tb_key_expand.sv
// tb/tb_key_expand.sv - directed self-checking bench for key_expand
module tb_key_expand;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [127:0] key_in = '0;
  logic         rk_ready = 1'b0;
  logic [127:0] round_key;
  logic [3:0]   round_idx;
  logic         rk_valid;
  logic         busy;
  logic         done;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  logic [127:0] fips_rk [11] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c,
    128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f,
    128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00,
    128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd,
    128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f,
    128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6
  };

  logic [127:0] zero_rk [11] = '{
    128'h00000000000000000000000000000000,
    128'h62636363626363636263636362636363,
    128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa,
    128'h90973450696ccffaf2f457330b0fac99,
    128'hee06da7b876a1581759e42b27e91ee2b,
    128'h7f2e2b88f8443e098dda7cbbf34b9290,
    128'hec614b851425758c99ff09376ab49ba7,
    128'h217517873550620bacaf6b3cc61bf09b,
    128'h0ef903333ba9613897060a04511dfa9f,
    128'hb1d4d8e28a7db9da1d7bb3de4c664941,
    128'hb4ef5bcb3e92e21123e951cf6f8f188e
  };

  key_expand dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .key_in    (key_in),
    .rk_ready  (rk_ready),
    .round_key (round_key),
    .round_idx (round_idx),
    .rk_valid  (rk_valid),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] exp_rk(input bit zero_key, input int k);
    return zero_key ? zero_rk[k] : fips_rk[k];
  endfunction

  // Full expansion with rk_ready held high; entered and left at a falling edge.
  task automatic run_full(input bit zero_key);
    key_in   = zero_key ? 128'h0 : FIPS_KEY;
    start    = 1'b1;
    rk_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k <= 10; k++) begin
      check($sformatf("full_valid_%0d", k), {127'h0, rk_valid}, 128'h1);
      check($sformatf("full_idx_%0d", k), {124'h0, round_idx}, k);
      check($sformatf("full_key_%0d", k), round_key, exp_rk(zero_key, k));
      check($sformatf("full_done_lo_%0d", k), {127'h0, done}, 128'h0);
      @(negedge clk);
    end
    check("full_done_pulse", {127'h0, done}, 128'h1);
    check("full_valid_off", {127'h0, rk_valid}, 128'h0);
    check("full_busy_off", {127'h0, busy}, 128'h0);
    check("full_idx_hold", {124'h0, round_idx}, 128'd10);
    check("full_key_hold", round_key, exp_rk(zero_key, 10));
    @(negedge clk);
    check("full_done_once", {127'h0, done}, 128'h0);
    rk_ready = 1'b0;
  endtask

  initial begin
    int  k;
    int  cyc;
    int  done_cnt;
    bit  pulsed4;

    // Reset state, observed before any clock edge.
    #1;
    check("rst_key", round_key, 128'h0);
    check("rst_idx", {124'h0, round_idx}, 128'h0);
    check("rst_valid", {127'h0, rk_valid}, 128'h0);
    check("rst_busy", {127'h0, busy}, 128'h0);
    check("rst_done", {127'h0, done}, 128'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Idle with start low: nothing happens, rk_ready is ignored.
    rk_ready = 1'b1;
    key_in   = FIPS_KEY;
    repeat (3) @(negedge clk);
    check("idle_valid", {127'h0, rk_valid}, 128'h0);
    check("idle_key", round_key, 128'h0);
    check("idle_idx", {124'h0, round_idx}, 128'h0);
    rk_ready = 1'b0;

    // FIPS-197 key, no back-pressure.
    run_full(1'b0);

    // All-zero key, no back-pressure.
    run_full(1'b1);

    // FIPS key with random stalls and stray start pulses at idx 4 and the final handshake.
    key_in   = FIPS_KEY;
    start    = 1'b1;
    rk_ready = 1'b0;
    @(negedge clk);
    start    = 1'b0;
    k        = 0;
    cyc      = 0;
    done_cnt = 0;
    pulsed4  = 1'b0;
    while (k <= 10 && cyc < 300) begin
      check($sformatf("bp_valid_%0d", k), {127'h0, rk_valid}, 128'h1);
      check($sformatf("bp_idx_%0d", k), {124'h0, round_idx}, k);
      check($sformatf("bp_key_%0d", k), round_key, fips_rk[k]);
      rk_ready = 1'($urandom_range(0, 1));
      if (k == 4 && !pulsed4) begin
        start   = 1'b1;
        key_in  = 128'h0;
        pulsed4 = 1'b1;
      end
      if (k == 10 && rk_ready) begin
        start  = 1'b1;
        key_in = 128'h0;
      end
      @(posedge clk);
      if (rk_ready) k++;
      cyc++;
      @(negedge clk);
      start = 1'b0;
      if (done) done_cnt++;
    end
    check("bp_completed", k, 128'd11);
    rk_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("bp_no_restart_%0d", i), {127'h0, rk_valid}, 128'h0);
      @(negedge clk);
      if (done) done_cnt++;
    end
    check("bp_done_count", done_cnt, 128'd1);
    rk_ready = 1'b0;

    // Reset in the middle of an expansion, then restart with the zero key.
    key_in   = FIPS_KEY;
    start    = 1'b1;
    rk_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k     = 0;
    while (round_idx != 4'd6 && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("mid_reached_6", {124'h0, round_idx}, 128'd6);
    check("mid_key_6", round_key, fips_rk[6]);
    rk_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("arst_key", round_key, 128'h0);
    check("arst_idx", {124'h0, round_idx}, 128'h0);
    check("arst_valid", {127'h0, rk_valid}, 128'h0);
    check("arst_busy", {127'h0, busy}, 128'h0);
    check("arst_done", {127'h0, done}, 128'h0);
    @(negedge clk);
    rst_n    = 1'b1;
    rk_ready = 1'b1;
    @(negedge clk);
    check("post_rst_idle", {127'h0, rk_valid}, 128'h0);
    run_full(1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
